// File: rtl/branch_target_predictor_if.sv
// Predictor bus: fetch lookup, MEM-stage resolution, redirect and perf counters.
// The pipeline side is the master; the predictor is the slave.
interface branch_target_predictor_if #(
  parameter int unsigned XLEN = 32
);
  logic            bp_enable;
  logic            bp_flush;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_hit;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_pc;
  logic            mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic            mem_is_jump;
  logic            mem_taken;
  logic [XLEN-1:0] mem_target;
  logic            mem_pred_taken;
  logic [XLEN-1:0] mem_pred_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispred;

  modport master (
    output bp_enable, bp_flush, if_pc,
    output mem_valid, mem_pc, mem_is_jump, mem_taken, mem_target, mem_pred_taken, mem_pred_pc,
    input  if_pred_hit, if_pred_taken, if_pred_pc,
    input  redirect, redirect_pc, perf_branches, perf_mispred
  );

  modport slave (
    input  bp_enable, bp_flush, if_pc,
    input  mem_valid, mem_pc, mem_is_jump, mem_taken, mem_target, mem_pred_taken, mem_pred_pc,
    output if_pred_hit, if_pred_taken, if_pred_pc,
    output redirect, redirect_pc, perf_branches, perf_mispred
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// MEM-stage training and misprediction redirect, saturating perf counters.
module branch_target_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CNT_INIT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_target_predictor_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [1:0]  CNT_RST = 2'(CNT_INIT);

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [1:0]          cnt_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];
  logic [31:0]         perf_br_q;
  logic [31:0]         perf_mis_q;

  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic                lk_taken;
  logic [IDX_W-1:0]    up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [1:0]          up_cnt;
  logic                mispred;

  always_comb begin
    lk_idx   = bp.if_pc[IDX_W+1:2];
    lk_tag   = bp.if_pc[IDX_W+TAG_BITS+1:IDX_W+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = bp.bp_enable && lk_hit && cnt_q[lk_idx][1];
  end

  assign bp.if_pred_hit   = lk_hit;
  assign bp.if_pred_taken = lk_taken;
  assign bp.if_pred_pc    = lk_taken ? tgt_q[lk_idx] : bp.if_pc + XLEN'(4);

  always_comb begin
    up_idx = bp.mem_pc[IDX_W+1:2];
    up_tag = bp.mem_pc[IDX_W+TAG_BITS+1:IDX_W+2];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_cnt = cnt_q[up_idx];
    if (bp.mem_is_jump) begin
      up_cnt = 2'b11;
    end else if (bp.mem_taken) begin
      if (cnt_q[up_idx] != 2'b11) up_cnt = cnt_q[up_idx] + 2'd1;
    end else begin
      if (cnt_q[up_idx] != 2'b00) up_cnt = cnt_q[up_idx] - 2'd1;
    end
  end

  // Gated by rst so redirect reads 0 for the whole reset window, not just after it.
  assign mispred = bp.mem_valid && !rst &&
                   ((bp.mem_taken != bp.mem_pred_taken) ||
                    (bp.mem_taken && (bp.mem_target != bp.mem_pred_pc)));

  assign bp.redirect      = mispred;
  assign bp.redirect_pc   = bp.mem_taken ? bp.mem_target : bp.mem_pc + XLEN'(4);
  assign bp.perf_branches = perf_br_q;
  assign bp.perf_mispred  = perf_mis_q;

  // Flush takes priority over a same-edge training update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_RST;
        tgt_q[i]   <= '0;
      end
    end else if (bp.bp_flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (bp.mem_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= up_cnt;
        if (bp.mem_taken) tgt_q[up_idx] <= bp.mem_target;
      end else if (bp.mem_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= bp.mem_target;
        cnt_q[up_idx]   <= bp.mem_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (bp.mem_valid && (perf_br_q != '1)) perf_br_q <= perf_br_q + 32'd1;
      if (mispred && (perf_mis_q != '1))     perf_mis_q <= perf_mis_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor (16 entries, 8-bit tags, CNT_INIT=1).
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.XLEN(32)) bus ();

  branch_target_predictor #(
    .XLEN(32), .ENTRIES(16), .TAG_BITS(8), .CNT_INIT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp(bus)
  );

  typedef enum {S_HIT, S_TAKEN, S_PRED_PC, S_REDIR, S_REDIR_PC, S_BR, S_MIS} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mis = '0;

  function automatic logic [31:0] obs(sig_e s);
    case (s)
      S_HIT:      return {31'b0, bus.if_pred_hit};
      S_TAKEN:    return {31'b0, bus.if_pred_taken};
      S_PRED_PC:  return bus.if_pred_pc;
      S_REDIR:    return {31'b0, bus.redirect};
      S_REDIR_PC: return bus.redirect_pc;
      S_BR:       return bus.perf_branches;
      default:    return bus.perf_mispred;
    endcase
  endfunction

  task automatic push(sig_e s, logic [31:0] v, string n);
    sb.push_back('{sig: s, val: v, name: n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_mem();
    bus.mem_valid      = 1'b0;
    bus.mem_pc         = '0;
    bus.mem_is_jump    = 1'b0;
    bus.mem_taken      = 1'b0;
    bus.mem_target     = '0;
    bus.mem_pred_taken = 1'b0;
    bus.mem_pred_pc    = '0;
  endtask

  task automatic mem_update(logic [31:0] pc, logic jump, logic taken, logic [31:0] target,
                            logic ptaken, logic [31:0] ppc, logic redir);
    bus.mem_valid      = 1'b1;
    bus.mem_pc         = pc;
    bus.mem_is_jump    = jump;
    bus.mem_taken      = taken;
    bus.mem_target     = target;
    bus.mem_pred_taken = ptaken;
    bus.mem_pred_pc    = ppc;
    exp_br = exp_br + 32'd1;
    if (redir) exp_mis = exp_mis + 32'd1;
    push(S_REDIR, {31'b0, redir}, "redirect");
    push(S_REDIR_PC, taken ? target : pc + 32'd4, "redirect_pc");
  endtask

  task automatic lookup(logic [31:0] pc, logic hit, logic taken, logic [31:0] ppc);
    bus.if_pc = pc;
    push(S_HIT, {31'b0, hit}, "if_pred_hit");
    push(S_TAKEN, {31'b0, taken}, "if_pred_taken");
    push(S_PRED_PC, ppc, "if_pred_pc");
  endtask

  task automatic push_perf();
    push(S_BR, exp_br, "perf_branches");
    push(S_MIS, exp_mis, "perf_mispred");
  endtask

  task automatic test_reset();
    exp_t e;
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h40; bus.mem_taken = 1'b1;
    bus.mem_target = 32'h100; bus.mem_pred_taken = 1'b0; bus.mem_pred_pc = 32'h44;
    lookup(32'h40, 1'b0, 1'b0, 32'h44);
    push(S_REDIR, 32'd0, "redirect_in_reset");
    push_perf();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL reset/%s: got %h, expected %h", e.name, obs(e.sig), e.val);
        end
      end
      if (k == 0) begin
        idle_mem();
        rst = 1'b0;
        tick();
        lookup(32'h40, 1'b0, 1'b0, 32'h44);
        push_perf();
      end
    end
  endtask

  task automatic test_allocate();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (k == 0) begin
        mem_update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1);
        lookup(32'h40, 1'b0, 1'b0, 32'h44);
      end else begin
        idle_mem();
        lookup(32'h40, 1'b1, 1'b1, 32'h100);
        push_perf();
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL allocate[%0d]/%s: got %h, expected %h", k, e.name, obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_counter();
    exp_t e;
    logic [7:0] tk;
    logic [7:0] after;
    logic cur;
    tk    = 8'b0011_1100;
    after = 8'b0111_1000;
    cur   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) begin
        mem_update(32'h40, 1'b0, tk[i], 32'h100, tk[i], tk[i] ? 32'h100 : 32'h44, 1'b0);
      end else begin
        idle_mem();
        push_perf();
      end
      lookup(32'h40, 1'b1, cur, cur ? 32'h100 : 32'h44);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL counter[%0d]/%s: got %h, expected %h", i, e.name, obs(e.sig), e.val);
        end
      end
      if (i < 8) cur = after[i];
    end
  endtask

  task automatic test_alias();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      tick();
      case (k)
        0: begin idle_mem(); lookup(32'h440, 1'b0, 1'b0, 32'h444); end
        1: begin
          mem_update(32'h440, 1'b0, 1'b1, 32'h300, 1'b0, 32'h444, 1'b1);
          lookup(32'h440, 1'b0, 1'b0, 32'h444);
        end
        2: begin idle_mem(); lookup(32'h40, 1'b0, 1'b0, 32'h44); end
        default: begin lookup(32'h440, 1'b1, 1'b1, 32'h300); push_perf(); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL alias[%0d]/%s: got %h, expected %h", k, e.name, obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      tick();
      case (k)
        0: begin
          mem_update(32'h80, 1'b0, 1'b1, 32'h180, 1'b0, 32'h84, 1'b1);
          lookup(32'h80, 1'b0, 1'b0, 32'h84);
        end
        1: begin
          mem_update(32'h80, 1'b0, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1);
          lookup(32'h80, 1'b1, 1'b1, 32'h180);
        end
        2: begin
          mem_update(32'h80, 1'b1, 1'b1, 32'h200, 1'b1, 32'h180, 1'b1);
          lookup(32'h80, 1'b1, 1'b0, 32'h84);
        end
        3: begin
          mem_update(32'h80, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1);
          lookup(32'h80, 1'b1, 1'b1, 32'h200);
        end
        default: begin idle_mem(); lookup(32'h80, 1'b1, 1'b1, 32'h200); push_perf(); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL jump[%0d]/%s: got %h, expected %h", k, e.name, obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_flush_enable();
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      tick();
      case (k)
        0: begin
          bus.bp_flush = 1'b1;
          mem_update(32'h84, 1'b0, 1'b1, 32'h400, 1'b0, 32'h88, 1'b1);
          lookup(32'h80, 1'b1, 1'b1, 32'h200);
        end
        1: begin
          bus.bp_flush = 1'b0;
          idle_mem();
          lookup(32'h80, 1'b0, 1'b0, 32'h84);
          push_perf();
        end
        2: lookup(32'h84, 1'b0, 1'b0, 32'h88);
        3: begin
          mem_update(32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84, 1'b1);
          lookup(32'h80, 1'b0, 1'b0, 32'h84);
        end
        4: begin
          idle_mem();
          bus.bp_enable = 1'b0;
          lookup(32'h80, 1'b1, 1'b0, 32'h84);
        end
        5: begin
          mem_update(32'h80, 1'b0, 1'b0, 32'h200, 1'b0, 32'h84, 1'b0);
          lookup(32'h80, 1'b1, 1'b0, 32'h84);
        end
        default: begin
          idle_mem();
          bus.bp_enable = 1'b1;
          lookup(32'h80, 1'b1, 1'b0, 32'h84);
          push_perf();
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL flush_enable[%0d]/%s: got %h, expected %h", k, e.name, obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    tick();
    bus.if_pc = 32'h80;
    mem_update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1);
    sb.delete();
    #1;
    rst = 1'b1;
    exp_br  = '0;
    exp_mis = '0;
    #1;
    lookup(32'h80, 1'b0, 1'b0, 32'h84);
    push(S_REDIR, 32'd0, "redirect_in_reset");
    push_perf();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL async_reset[%0d]/%s: got %h, expected %h", k, e.name, obs(e.sig), e.val);
        end
      end
      if (k == 0) begin
        @(negedge clk);
        idle_mem();
        @(negedge clk);
        rst = 1'b0;
        tick();
        lookup(32'h40, 1'b0, 1'b0, 32'h44);
        push_perf();
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.bp_enable = 1'b1;
    bus.bp_flush  = 1'b0;
    bus.if_pc     = 32'h40;
    idle_mem();
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_jump();
    test_flush_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
